// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with byte/halfword/word
// writes, programmable data-phase wait states and two-cycle ERROR responses.
module ahb3lite_sram_slave #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [WORD_W-1:0]  word_q;
    logic               write_q;
    logic [3:0]         be_q;

    logic [31:0]        mem [MEM_WORDS];

    logic               can_accept;
    logic               accept;
    logic               xfer_err;
    logic               acc_ok;
    logic               acc_err;
    logic [3:0]         be_d;
    logic               commit;
    logic [WORD_W-1:0]  rd_word;
    logic               load_rd;
    logic [31:0]        wr_old;
    logic [31:0]        merged;
    logic [31:0]        rd_data;

    // Address, burst type and HTRANS[0] are outside the decoded space.
    logic unused_bits;
    assign unused_bits = &{1'b0, HADDR[31:12], HTRANS[0], HBURST};

    // Address-phase decode: acceptance, error classification and byte lanes.
    always_comb begin
        can_accept = 1'b0;
        xfer_err   = 1'b0;
        be_d       = 4'h0;
        can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
        accept     = HSEL && HREADY && HTRANS[1] && can_accept;
        xfer_err   = (HSIZE > 3'b010)
                  || ((HSIZE == 3'b001) && HADDR[0])
                  || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                  || (32'(HADDR[11:2]) >= MEM_WORDS);
        acc_ok     = accept && !xfer_err;
        acc_err    = accept && xfer_err;
        case (HSIZE[1:0])
            2'b00:   be_d = 4'(4'b0001 << HADDR[1:0]);
            2'b01:   be_d = HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_d = 4'b1111;
        endcase
    end

    // Write merge and read path; a read entering DATA on a commit edge sees the merged word.
    always_comb begin
        commit  = (state == ST_DATA) && write_q && !HRESET;
        wr_old  = mem[IDX_W'(word_q)];
        merged  = wr_old;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
        end
        rd_word = (state == ST_WAIT) ? word_q : HADDR[11:2];
        load_rd = (acc_ok && !HWRITE && (WAIT_STATES == 0))
               || ((state == ST_WAIT) && (wait_cnt == '0) && !write_q);
        rd_data = (commit && (word_q == rd_word)) ? merged : mem[IDX_W'(rd_word)];
    end

    always_ff @(posedge HCLK) begin
        if (commit) mem[IDX_W'(word_q)] <= merged;
    end

    // Transfer FSM with registered bus responses.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            wait_cnt  <= '0;
            word_q    <= '0;
            write_q   <= 1'b0;
            be_q      <= '0;
        end else begin
            if (accept) begin
                word_q  <= HADDR[11:2];
                write_q <= HWRITE;
                be_q    <= be_d;
            end
            if (load_rd) HRDATA <= rd_data;

            case (state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (acc_err) begin
                        state     <= ST_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end else if (acc_ok && (WAIT_STATES > 0)) begin
                        state     <= ST_WAIT;
                        wait_cnt  <= CNT_W'(WAIT_STATES - 1);
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b0;
                    end else if (acc_ok) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end else begin
                        wait_cnt  <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Scoreboard bench for ahb3lite_sram_slave: one zero-wait and one three-wait instance.
module tb_ahb3lite_sram_slave;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        sel0, sel3;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [31:0] rdata0, rdata3;
    logic        ro0, ro3, resp0, resp3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [2][256];
    exp_t        q0[$];
    exp_t        q3[$];
    bit          dp_valid [2];
    int          dp_waits [2];
    exp_t        dp_item  [2];
    logic [31:0] pend_wdata = '0;
    int          last_cycles;

    always #5 HCLK = ~HCLK;

    ahb3lite_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(ro0), .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0)
    );

    ahb3lite_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel3), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(ro3), .HRDATA(rdata3), .HREADYOUT(ro3), .HRESP(resp3)
    );

    // Data-phase monitor: tracks each accepted transfer and checks its response.
    task automatic mon(input int d, input logic sel, input logic rdy, input logic resp,
                       input logic [31:0] rdata);
        int ws;
        ws = (d == 0) ? 0 : 3;
        if (dp_valid[d]) begin
            if (!rdy) begin
                dp_waits[d]++;
                checks++;
                if (resp !== dp_item[d].err) begin
                    errors++;
                    $display("FAIL d%0d stall_hresp: got %b expected %b", d, resp, dp_item[d].err);
                end
            end else begin
                checks++;
                if (resp !== dp_item[d].err) begin
                    errors++;
                    $display("FAIL d%0d final_hresp: got %b expected %b", d, resp, dp_item[d].err);
                end
                checks++;
                if (dp_waits[d] !== (dp_item[d].err ? 1 : ws)) begin
                    errors++;
                    $display("FAIL d%0d stall_cycles: got %0d expected %0d", d, dp_waits[d],
                             dp_item[d].err ? 1 : ws);
                end
                if (dp_item[d].rd && !dp_item[d].err) begin
                    checks++;
                    if (rdata !== dp_item[d].data) begin
                        errors++;
                        $display("FAIL d%0d hrdata: got %h expected %h", d, rdata, dp_item[d].data);
                    end
                end
                dp_valid[d] = 1'b0;
            end
        end
        if (HRESET) begin
            dp_valid[d] = 1'b0;
        end else if (sel && rdy && htrans[1]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q3.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL d%0d scoreboard_empty: got accept expected none", d);
            end else begin
                dp_item[d]  = (d == 0) ? q0.pop_front() : q3.pop_front();
                dp_valid[d] = 1'b1;
                dp_waits[d] = 0;
            end
        end
    endtask

    always @(negedge HCLK) begin
        mon(0, sel0, ro0, resp0, rdata0);
        mon(1, sel3, ro3, resp3, rdata3);
    end

    task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
        logic [3:0] be;
        logic [31:0] w;
        case (size)
            3'd0:    be = 4'(4'b0001 << addr[1:0]);
            3'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        w = model[d][addr[9:2]];
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        model[d][addr[9:2]] = w;
    endtask

    // Drives one address phase (overlapping the previous data phase) and waits for its accept.
    task automatic issue(input int d, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input bit upd = 1'b1);
        exp_t e;
        int   n;
        bit   rdy;
        e.err  = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
                 (size == 3'd2 && addr[1:0] != 2'b00) || (addr[11:2] >= 10'd256);
        e.rd   = !wr;
        e.data = '0;
        if (!e.err) begin
            if (wr) begin
                if (upd) model_write(d, addr, size, wdata);
            end else begin
                e.data = model[d][addr[9:2]];
            end
        end
        if (d == 0) q0.push_back(e); else q3.push_back(e);
        sel0 = (d == 0); sel3 = (d == 1);
        haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10; hburst = 3'b000;
        hwdata = pend_wdata;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge HCLK);
            rdy = (d == 0) ? ro0 : ro3;
            @(posedge HCLK); #1;
            n++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL d%0d accept_timeout: got no accept expected accept within 50", d);
        end
        last_cycles = n;
        pend_wdata = wdata;
    endtask

    // Ends the pipeline: IDLE address phases until the last data phase completes.
    task automatic idle(input int cycles);
        int n;
        bit rdy;
        htrans = 2'b00;
        hwdata = pend_wdata;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge HCLK);
            rdy = ro0 && ro3;
            @(posedge HCLK); #1;
            n++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got busy expected idle within 50");
        end
        sel0 = 1'b0; sel3 = 1'b0;
        repeat (cycles) begin @(posedge HCLK); #1; end
    endtask

    task automatic test_reset;
        HRESET = 1'b1; sel0 = 0; sel3 = 0; htrans = 2'b00; hwrite = 0;
        haddr = '0; hsize = 3'd2; hburst = '0; hwdata = '0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        checks++; if (ro0 !== 1'b1)   begin errors++; $display("FAIL reset_ready0: got %b expected 1", ro0); end
        checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0: got %b expected 0", resp0); end
        checks++; if (rdata0 !== '0)  begin errors++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
        checks++; if (ro3 !== 1'b1)   begin errors++; $display("FAIL reset_ready3: got %b expected 1", ro3); end
        checks++; if (resp3 !== 1'b0) begin errors++; $display("FAIL reset_resp3: got %b expected 0", resp3); end
        checks++; if (rdata3 !== '0)  begin errors++; $display("FAIL reset_rdata3: got %h expected 0", rdata3); end
        @(posedge HCLK); #1;
    endtask

    task automatic test_write_read;
        issue(0, 1, 32'h010, 3'd2, 32'hDEADBEEF);
        issue(0, 0, 32'h010, 3'd2, 32'h0);
        idle(1);
    endtask

    task automatic test_byte_halfword;
        issue(0, 1, 32'h020, 3'd2, 32'h11223344);
        issue(0, 1, 32'h021, 3'd0, 32'h0000AA00);
        issue(0, 1, 32'h022, 3'd1, 32'hBBCC0000);
        issue(0, 0, 32'h020, 3'd2, 32'h0);
        idle(1);
        checks++;
        if (model[0][8] !== 32'hBBCCAA44) begin
            errors++; $display("FAIL lane_model: got %h expected bbccaa44", model[0][8]);
        end
    endtask

    task automatic test_hazard;
        issue(0, 1, 32'h030, 3'd2, 32'h0);
        issue(0, 1, 32'h030, 3'd0, 32'h00000055);
        issue(0, 0, 32'h030, 3'd2, 32'h0);
        issue(0, 1, 32'h032, 3'd1, 32'h12340000);
        issue(0, 0, 32'h030, 3'd2, 32'h0);
        idle(1);
    endtask

    task automatic test_errors;
        issue(0, 1, 32'h000, 3'd2, 32'h01020304);
        issue(0, 1, 32'h002, 3'd2, 32'hFFFFFFFF);
        issue(0, 1, 32'h010, 3'd3, 32'hFFFFFFFF);
        issue(0, 1, 32'h400, 3'd2, 32'hFFFFFFFF);
        issue(0, 1, 32'h021, 3'd1, 32'hFFFFFFFF);
        issue(0, 0, 32'h000, 3'd2, 32'h0);
        issue(0, 0, 32'h010, 3'd2, 32'h0);
        issue(0, 0, 32'h020, 3'd2, 32'h0);
        idle(1);
    endtask

    task automatic test_no_access;
        sel0 = 1'b1; htrans = 2'b01; haddr = 32'h002; hwrite = 1'b1;
        @(negedge HCLK);
        checks++;
        if (ro0 !== 1'b1 || resp0 !== 1'b0) begin
            errors++; $display("FAIL busy_okay: got %b%b expected 10", ro0, resp0);
        end
        @(posedge HCLK); #1;
        @(negedge HCLK);
        checks++;
        if (ro0 !== 1'b1 || resp0 !== 1'b0) begin
            errors++; $display("FAIL busy_after: got %b%b expected 10", ro0, resp0);
        end
        @(posedge HCLK); #1;
        htrans = 2'b00; sel0 = 1'b0;
    endtask

    task automatic test_wait_states;
        issue(1, 1, 32'h004, 3'd2, 32'hA5A55A5A);
        issue(1, 1, 32'h008, 3'd2, 32'h0BADF00D);
        issue(1, 0, 32'h004, 3'd2, 32'h0);
        issue(1, 0, 32'h008, 3'd2, 32'h0);
        checks++;
        if (last_cycles !== 4) begin
            errors++; $display("FAIL wait_accept_cycles: got %0d expected 4", last_cycles);
        end
        issue(1, 1, 32'h009, 3'd0, 32'h0000EE00);
        issue(1, 0, 32'h008, 3'd2, 32'h0);
        issue(1, 1, 32'h00A, 3'd2, 32'h0);
        issue(1, 0, 32'h008, 3'd2, 32'h0);
        idle(1);
    endtask

    task automatic test_reset_mid_write;
        issue(0, 1, 32'h040, 3'd2, 32'h12345678);
        issue(0, 0, 32'h040, 3'd2, 32'h0);
        issue(0, 1, 32'h040, 3'd2, 32'hCAFEF00D, 1'b0);
        HRESET = 1'b1; htrans = 2'b00; hwdata = 32'hCAFEF00D;
        @(posedge HCLK); #1;
        HRESET = 1'b0; sel0 = 1'b0;
        pend_wdata = '0;
        @(negedge HCLK);
        checks++; if (ro0 !== 1'b1)   begin errors++; $display("FAIL midrst_ready: got %b expected 1", ro0); end
        checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL midrst_resp: got %b expected 0", resp0); end
        checks++; if (rdata0 !== '0)  begin errors++; $display("FAIL midrst_rdata: got %h expected 0", rdata0); end
        @(posedge HCLK); #1;
        issue(0, 0, 32'h040, 3'd2, 32'h0);
        idle(1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            issue(0, 1, 32'h100 + 32'(4 * i), 3'd2, r);
        end
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            issue(0, 1, 32'h100 + 32'(4 * i) + 32'(i % 4), 3'd0, r);
            issue(0, 0, 32'h100 + 32'(4 * i), 3'd2, 32'h0);
        end
        for (int i = 0; i < 8; i++) issue(0, 0, 32'h100 + 32'(4 * i), 3'd2, 32'h0);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_halfword();
        test_hazard();
        test_errors();
        test_no_access();
        test_wait_states();
        test_reset_mid_write();
        test_back_to_back();
        checks++;
        if (q0.size() != 0 || q3.size() != 0 || dp_valid[0] || dp_valid[1]) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q0.size(), q3.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
